dcache_sram: RTL and testbench
==============================

// Module: dcache_sram
// PURPOSE
// - Storage array of the L1 data cache: 4-way set-associative, write-back, LRU replacement.
// - Sits under the D-cache controller FSM, which drives read/write lookups and memory refills.
// - Provides combinational hit detection, plus victim data and victim dirty status for write-back.
// PARAMETERS (global defines in constants.vh)
// - DTAG_SIZE          3   tag bits
// - DSET_INDEX_SIZE    1   set-index bits (2 sets)
// - DBLOCK_SIZE        8   bytes per block (width of byte-enable mask)
// - DBLOCK_SIZE_BITS   64  bits per block (8*DBLOCK_SIZE)
// - DWAYS              4   associativity
// PORTS
// - clk          in   1                     rising-edge clock
// - rst          in   1                     synchronous, active-high reset
// - ren          in   1                     CPU read lookup
// - wen          in   1                     CPU write lookup
// - memWen       in   1                     refill: write the whole block from memory
// - bytesAccess  in   DBLOCK_SIZE           byte enables for wen; bit i -> dataIn[8i+7:8i]
// - blockAddr    in   DTAG_SIZE+DSET_INDEX_SIZE   {tag, set}; set = LSBs
// - dataIn       in   DBLOCK_SIZE_BITS      write data (CPU write or refill block)
// - hit          out  1                     valid tag match in the addressed set
// - dirtyBit     out  1                     on a miss: the victim way is valid and dirty
// - dataOut      out  DBLOCK_SIZE_BITS      hit: hit-way block; miss: victim-way block
// BEHAVIOUR
// - Per way/set state: valid, dirty, tag, data, 2-bit LRU age (0 = MRU, 3 = LRU).
// - Reset (rst=1 at posedge): clear all valid/dirty bits; set ages to way index (way0=0 .. way3=3).
// - While rst=1, hit, dirtyBit and dataOut are forced to 0; data contents are don't-care.
// - Outputs are combinational from blockAddr and the current state (0-cycle lookup).
// - hit = ren|wen asserted, and some way in the set is valid with a matching tag; 0 otherwise.
// - Victim way: lowest-index invalid way if one exists; else the way with age 3.
// - Miss outputs: dirtyBit = victim valid & dirty; dataOut = victim data (the write-back source).
// - Hit outputs: dirtyBit = 0; dataOut = hit-way data.
// - Updates happen at posedge, with priority memWen > wen > ren (lower-priority requests are ignored):
//   - memWen: the victim way takes tag = blockAddr tag and data = dataIn; set valid=1, dirty=0; touch LRU.
//   - wen & hit: for each i with bytesAccess[i]=1, replace byte i; set dirty=1; touch LRU.
//   - wen & miss: no state change. The controller refills via memWen and then retries the write.
//   - ren & hit: touch LRU only. ren & miss: no state change.
// - LRU touch of way w with old age a: ways with age < a increment; w becomes 0. Ages stay a permutation.
// - memWen to a tag already present is the controller's error; the state after it is undefined.
// - Only the addressed set is modified; other sets hold their state.
// STRUCTURE
// - constants.vh: D* size macros, DWAYS, and the age width.
// - Sub-module dcache_lru: per-set age registers, victim select, and touch logic.
// - Top level holds the tag/valid/dirty/data arrays, tag compare, and output mux.
// TESTING
// - Reset, then wen with set0, tag000, bytes 0xF0 -> hit=0, dirtyBit=0 (victim way0 is invalid).
// - memWen with set0, tag000, data all-ones; next cycle ren tag000 -> hit=1, dataOut=64'hFFFF_FFFF_FFFF_FFFF.
// - wen with tag000, bytes 0xF0, data 64'hAAAAAAAA_00000000 -> hit=1.
//   Then ren tag000 -> dataOut=64'hAAAAAAAA_FFFFFFFF.
// - Refill tags 001, 010 and 100 (tag001 data 64'h00000000_FFFFFFFF); ren tag000 -> hit.
//   Then ren tag111 -> hit=0, dirtyBit=0, dataOut=64'h00000000_FFFFFFFF (victim = tag001).
// - Touch tags 001, 010 and 100 so tag000 becomes LRU; ren tag111 -> hit=0, dirtyBit=1,
//   dataOut=64'hAAAAAAAA_FFFFFFFF.
// - Assert rst mid-sequence, then ren tag000 -> hit=0, dirtyBit=0; set1 is unaffected by all set0 traffic.

Source files
------------

// File: rtl/dcache_sram_pkg.sv
// dcache_sram_pkg: shared sizes and types for the L1 data-cache storage array.
// 4-way set-associative, 2 sets, 8-byte blocks, 3-bit tags, 2-bit LRU ages.
package dcache_sram_pkg;
  localparam int DTAG_SIZE        = 3;
  localparam int DSET_INDEX_SIZE  = 1;
  localparam int DBLOCK_SIZE      = 8;
  localparam int DBLOCK_SIZE_BITS = 8 * DBLOCK_SIZE;
  localparam int DWAYS            = 4;
  localparam int DAGE_SIZE        = 2;
  localparam int DSETS            = 1 << DSET_INDEX_SIZE;
  localparam int DWAY_IDX_SIZE    = 2;
  localparam int DADDR_SIZE       = DTAG_SIZE + DSET_INDEX_SIZE;

  typedef logic [DTAG_SIZE-1:0]        tag_t;
  typedef logic [DSET_INDEX_SIZE-1:0]  set_t;
  typedef logic [DWAY_IDX_SIZE-1:0]    way_t;
  typedef logic [DAGE_SIZE-1:0]        age_t;
  typedef logic [DBLOCK_SIZE_BITS-1:0] block_t;
  typedef logic [DBLOCK_SIZE-1:0]      byteMask_t;

  localparam age_t AGE_LRU = age_t'(DWAYS - 1);

  // Byte-granular merge: byte i of newData replaces byte i of oldData where mask[i] is set.
  function automatic block_t mergeBytes(block_t oldData, block_t newData, byteMask_t mask);
    block_t r;
    r = oldData;
    for (int i = 0; i < DBLOCK_SIZE; i++)
      if (mask[i]) r[8*i +: 8] = newData[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/dcache_sram_if.sv
// dcache_sram_if: request/response bundle between the D-cache controller (master)
// and the storage array (slave).
//   ren/wen/memWen  lookup and refill strobes
//   bytesAccess     byte enables for wen
//   blockAddr       {tag, set}
//   dataIn          CPU write data or refill block
//   hit/dirtyBit/dataOut  combinational lookup results
interface dcache_sram_if;
  import dcache_sram_pkg::*;
  logic                  ren;
  logic                  wen;
  logic                  memWen;
  byteMask_t             bytesAccess;
  logic [DADDR_SIZE-1:0] blockAddr;
  block_t                dataIn;
  logic                  hit;
  logic                  dirtyBit;
  block_t                dataOut;

  modport master (output ren, wen, memWen, bytesAccess, blockAddr, dataIn,
                  input  hit, dirtyBit, dataOut);
  modport slave  (input  ren, wen, memWen, bytesAccess, blockAddr, dataIn,
                  output hit, dirtyBit, dataOut);
endinterface

// File: rtl/dcache_lru.sv
// dcache_lru: per-set LRU ages, victim selection and touch update.
//   clk, rst   clock, synchronous active-high reset (ages <- way index)
//   set        addressed set
//   validVec   valid bits of the addressed set's ways
//   touch      make touchWay MRU at the next edge
//   touchWay   way to promote
//   victimWay  lowest invalid way, else the way with age LRU
module dcache_lru
  import dcache_sram_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  set_t             set,
  input  logic [DWAYS-1:0] validVec,
  input  logic             touch,
  input  way_t             touchWay,
  output way_t             victimWay
);
  age_t age [DSETS][DWAYS];

  always_comb begin
    logic found;
    victimWay = '0;
    found     = 1'b0;
    for (int w = 0; w < DWAYS; w++)
      if (!validVec[w] && !found) begin
        victimWay = way_t'(w);
        found     = 1'b1;
      end
    // Ages form a permutation, so exactly one way holds AGE_LRU.
    if (!found)
      for (int w = 0; w < DWAYS; w++)
        if (age[set][w] == AGE_LRU) victimWay = way_t'(w);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < DSETS; s++)
        for (int w = 0; w < DWAYS; w++)
          age[s][w] <= age_t'(w);
    end else if (touch) begin
      // Only ways younger than the touched one age; older ways keep their rank.
      for (int w = 0; w < DWAYS; w++)
        if (way_t'(w) == touchWay)
          age[set][w] <= '0;
        else if (age[set][w] < age[set][touchWay])
          age[set][w] <= age[set][w] + age_t'(1);
    end
  end
endmodule

// File: rtl/dcache_sram.sv
// dcache_sram: L1 D-cache storage (tag/valid/dirty/data arrays), tag compare and
// output mux; write-back, LRU replacement via dcache_lru.
//   clk, rst  clock, synchronous active-high reset
//   bus       dcache_sram_if.slave: lookups, refills, and combinational results
// Update priority at the clock edge: memWen > wen > ren.
module dcache_sram
  import dcache_sram_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  dcache_sram_if.slave  bus
);
  logic [DWAYS-1:0] valid [DSETS];
  logic [DWAYS-1:0] dirty [DSETS];
  tag_t             tags  [DSETS][DWAYS];
  block_t           data  [DSETS][DWAYS];

  set_t             set;
  tag_t             tagIn;
  logic [DWAYS-1:0] match;
  logic             hitAny;
  logic             lookup;
  way_t             hitWay;
  way_t             victimWay;
  logic             wenHit;
  logic             touch;

  assign set    = bus.blockAddr[DSET_INDEX_SIZE-1:0];
  assign tagIn  = bus.blockAddr[DADDR_SIZE-1:DSET_INDEX_SIZE];
  assign lookup = bus.ren | bus.wen;

  for (genvar w = 0; w < DWAYS; w++) begin : gWay
    assign match[w] = valid[set][w] && (tags[set][w] == tagIn);
  end

  assign hitAny = |match;

  always_comb begin
    hitWay = '0;
    for (int w = 0; w < DWAYS; w++)
      if (match[w]) hitWay = way_t'(w);
  end

  assign wenHit = !bus.memWen && bus.wen && hitAny;
  assign touch  = bus.memWen || (lookup && hitAny);

  dcache_lru uLru (
    .clk       (clk),
    .rst       (rst),
    .set       (set),
    .validVec  (valid[set]),
    .touch     (touch),
    .touchWay  (bus.memWen ? victimWay : hitWay),
    .victimWay (victimWay)
  );

  // Miss path exposes the victim so the controller can write it back before refilling.
  always_comb begin
    bus.hit      = 1'b0;
    bus.dirtyBit = 1'b0;
    bus.dataOut  = '0;
    if (!rst) begin
      if (lookup && hitAny) begin
        bus.hit     = 1'b1;
        bus.dataOut = data[set][hitWay];
      end else begin
        bus.dirtyBit = valid[set][victimWay] && dirty[set][victimWay];
        bus.dataOut  = data[set][victimWay];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < DSETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
      end
    end else if (bus.memWen) begin
      valid[set][victimWay] <= 1'b1;
      dirty[set][victimWay] <= 1'b0;
    end else if (wenHit) begin
      dirty[set][hitWay] <= 1'b1;
    end
  end

  // Tag/data arrays carry no reset; valid bits gate their meaning.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (bus.memWen) begin
        tags[set][victimWay] <= tagIn;
        data[set][victimWay] <= bus.dataIn;
      end else if (wenHit) begin
        data[set][hitWay] <= mergeBytes(data[set][hitWay], bus.dataIn, bus.bytesAccess);
      end
    end
  end
endmodule

// File: tb/tb_dcache_sram.sv
module tb_dcache_sram;
  logic clk = 1'b0;
  logic rst;
  int   nTests = 0;
  int   nFail  = 0;

  dcache_sram_if bus ();
  dcache_sram dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: per-set recency list (index 0 = most recent) instead of ages.
  logic        mValid [2][4];
  logic        mDirty [2][4];
  logic [2:0]  mTag   [2][4];
  logic [63:0] mData  [2][4];
  int          mOrder [2][4];

  logic        eHit, eDirty, eCare;
  logic [63:0] eData;

  function automatic logic [3:0] A(input logic [2:0] t, input logic s);
    return {t, s};
  endfunction

  function automatic void mReset();
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 4; w++) begin
        mValid[s][w] = 1'b0; mDirty[s][w] = 1'b0; mOrder[s][w] = w;
      end
  endfunction

  function automatic int mFind(input int s, input logic [2:0] t);
    for (int w = 0; w < 4; w++) if (mValid[s][w] && mTag[s][w] == t) return w;
    return -1;
  endfunction

  function automatic int mVictim(input int s);
    for (int w = 0; w < 4; w++) if (!mValid[s][w]) return w;
    return mOrder[s][3];
  endfunction

  function automatic void mTouch(input int s, input int w);
    int p = 0;
    for (int i = 0; i < 4; i++) if (mOrder[s][i] == w) p = i;
    for (int i = p; i > 0; i--) mOrder[s][i] = mOrder[s][i-1];
    mOrder[s][0] = w;
  endfunction

  function automatic void eval();
    int s, hw, v;
    s = int'(bus.blockAddr[0]);
    hw = mFind(s, bus.blockAddr[3:1]);
    v = mVictim(s);
    eHit = 1'b0; eDirty = 1'b0; eData = '0; eCare = 1'b1;
    if (rst) return;
    if ((bus.ren || bus.wen) && hw >= 0) begin
      eHit = 1'b1; eData = mData[s][hw];
    end else begin
      eDirty = mValid[s][v] && mDirty[s][v];
      eData  = mData[s][v];
      eCare  = mValid[s][v];
    end
  endfunction

  function automatic void mUpdate();
    int s, hw, v;
    s = int'(bus.blockAddr[0]);
    hw = mFind(s, bus.blockAddr[3:1]);
    if (bus.memWen) begin
      v = mVictim(s);
      mValid[s][v] = 1'b1; mDirty[s][v] = 1'b0;
      mTag[s][v] = bus.blockAddr[3:1]; mData[s][v] = bus.dataIn;
      mTouch(s, v);
    end else if (bus.wen && hw >= 0) begin
      for (int i = 0; i < 8; i++)
        if (bus.bytesAccess[i]) mData[s][hw][8*i +: 8] = bus.dataIn[8*i +: 8];
      mDirty[s][hw] = 1'b1;
      mTouch(s, hw);
    end else if (bus.ren && hw >= 0) begin
      mTouch(s, hw);
    end
  endfunction

  task automatic apply(input logic r, input logic rn, input logic wn, input logic mw,
                       input logic [3:0] a, input logic [7:0] be, input logic [63:0] d);
    @(negedge clk);
    rst = r; bus.ren = rn; bus.wen = wn; bus.memWen = mw;
    bus.blockAddr = a; bus.bytesAccess = be; bus.dataIn = d;
    #1;
  endtask

  task automatic commit();
    @(posedge clk);
    if (rst) mReset(); else mUpdate();
  endtask

  task automatic test_reset();
    apply(1, 1, 1, 0, A(3'b000, 0), 8'hFF, '1);
    nTests++;
    if (bus.hit !== 1'b0 || bus.dirtyBit !== 1'b0 || bus.dataOut !== 64'h0) begin
      nFail++; $display("FAIL rst_forced got hit=%b dirty=%b data=%h exp 0/0/0", bus.hit, bus.dirtyBit, bus.dataOut);
    end
    commit();
    apply(1, 0, 0, 1, A(3'b010, 1), 8'h00, 64'h1234);
    commit();
    apply(0, 1, 0, 0, A(3'b000, 0), 8'h00, '0);
    nTests++;
    if (bus.hit !== 1'b0 || bus.dirtyBit !== 1'b0) begin
      nFail++; $display("FAIL rst_state got hit=%b dirty=%b exp 0/0", bus.hit, bus.dirtyBit);
    end
    commit();
    // Seed set1 so isolation from set0 traffic can be checked later.
    apply(0, 0, 0, 1, A(3'b101, 1), 8'h00, 64'h5A5A_5A5A_1234_5678);
    commit();
  endtask

  task automatic test_directed();
    apply(0, 0, 1, 0, A(3'b000, 0), 8'hF0, 64'hAAAAAAAA_00000000);
    nTests++;
    if (bus.hit !== 1'b0 || bus.dirtyBit !== 1'b0) begin
      nFail++; $display("FAIL wen_cold got hit=%b dirty=%b exp 0/0", bus.hit, bus.dirtyBit);
    end
    commit();
    apply(0, 0, 0, 1, A(3'b000, 0), 8'h00, '1); commit();
    apply(0, 1, 0, 0, A(3'b000, 0), 8'h00, '0);
    nTests++;
    if (bus.hit !== 1'b1 || bus.dataOut !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      nFail++; $display("FAIL refill_hit got hit=%b data=%h exp 1/ffffffffffffffff", bus.hit, bus.dataOut);
    end
    commit();
    apply(0, 0, 1, 0, A(3'b000, 0), 8'hF0, 64'hAAAAAAAA_00000000);
    nTests++;
    if (bus.hit !== 1'b1) begin
      nFail++; $display("FAIL wen_hit got hit=%b exp 1", bus.hit);
    end
    commit();
    apply(0, 1, 0, 0, A(3'b000, 0), 8'h00, '0);
    nTests++;
    if (bus.dataOut !== 64'hAAAAAAAA_FFFFFFFF) begin
      nFail++; $display("FAIL byte_merge got %h exp aaaaaaaaffffffff", bus.dataOut);
    end
    commit();
    apply(0, 0, 0, 1, A(3'b001, 0), 8'h00, 64'h00000000_FFFFFFFF); commit();
    apply(0, 0, 0, 1, A(3'b010, 0), 8'h00, 64'h11111111_11111111); commit();
    apply(0, 0, 0, 1, A(3'b100, 0), 8'h00, 64'h22222222_22222222); commit();
    apply(0, 1, 0, 0, A(3'b000, 0), 8'h00, '0);
    nTests++;
    if (bus.hit !== 1'b1) begin
      nFail++; $display("FAIL full_set_hit got hit=%b exp 1", bus.hit);
    end
    commit();
    apply(0, 1, 0, 0, A(3'b111, 0), 8'h00, '0);
    nTests++;
    if (bus.hit !== 1'b0 || bus.dirtyBit !== 1'b0 || bus.dataOut !== 64'h00000000_FFFFFFFF) begin
      nFail++; $display("FAIL clean_victim got hit=%b dirty=%b data=%h exp 0/0/00000000ffffffff",
                        bus.hit, bus.dirtyBit, bus.dataOut);
    end
    commit();
    for (int i = 0; i < 3; i++) begin
      logic [2:0] t;
      t = 3'b001 << i;
      apply(0, 1, 0, 0, A(t, 0), 8'h00, '0);
      nTests++;
      if (bus.hit !== 1'b1) begin
        nFail++; $display("FAIL touch_hit tag=%b got hit=%b exp 1", t, bus.hit);
      end
      commit();
    end
    apply(0, 1, 0, 0, A(3'b111, 0), 8'h00, '0);
    nTests++;
    if (bus.hit !== 1'b0 || bus.dirtyBit !== 1'b1 || bus.dataOut !== 64'hAAAAAAAA_FFFFFFFF) begin
      nFail++; $display("FAIL dirty_victim got hit=%b dirty=%b data=%h exp 0/1/aaaaaaaaffffffff",
                        bus.hit, bus.dirtyBit, bus.dataOut);
    end
    commit();
    // No lookup strobe: hit stays low even for a resident tag.
    apply(0, 0, 0, 0, A(3'b000, 0), 8'h00, '0);
    nTests++;
    if (bus.hit !== 1'b0) begin
      nFail++; $display("FAIL idle_nohit got hit=%b exp 0", bus.hit);
    end
    commit();
  endtask

  task automatic test_set_isolation();
    apply(0, 1, 0, 0, A(3'b101, 1), 8'h00, '0);
    nTests++;
    if (bus.hit !== 1'b1 || bus.dataOut !== 64'h5A5A_5A5A_1234_5678) begin
      nFail++; $display("FAIL set1_isolated got hit=%b data=%h exp 1/5a5a5a5a12345678", bus.hit, bus.dataOut);
    end
    commit();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [3:0] a;
      logic rn, wn, mw;
      int op;
      a = 4'($urandom_range(0, 15));
      op = $urandom_range(0, 5);
      rn = (op == 1 || op == 4); wn = (op == 2 || op == 4 || op == 5); mw = (op == 3 || op == 5);
      // Refilling a resident tag is a controller error; turn it into a read.
      if (mw && mFind(int'(a[0]), a[3:1]) >= 0) begin mw = 1'b0; rn = 1'b1; end
      apply(0, rn, wn, mw, a, 8'($urandom), {$urandom, $urandom});
      eval();
      nTests++;
      if (bus.hit !== eHit || bus.dirtyBit !== eDirty || (eCare && bus.dataOut !== eData)) begin
        nFail++; $display("FAIL rand_%0d addr=%h got hit=%b dirty=%b data=%h exp %b/%b/%h",
                          n, a, bus.hit, bus.dirtyBit, bus.dataOut, eHit, eDirty, eData);
      end
      commit();
    end
  endtask

  task automatic test_reset_mid();
    apply(1, 0, 1, 0, A(3'b000, 0), 8'hFF, '0);
    nTests++;
    if (bus.hit !== 1'b0 || bus.dirtyBit !== 1'b0 || bus.dataOut !== 64'h0) begin
      nFail++; $display("FAIL rst_mid_forced got hit=%b dirty=%b data=%h exp 0/0/0", bus.hit, bus.dirtyBit, bus.dataOut);
    end
    commit();
    for (int t = 0; t < 8; t++)
      for (int s = 0; s < 2; s++) begin
        apply(0, 1, 0, 0, A(3'(t), 1'(s)), 8'h00, '0);
        nTests++;
        if (bus.hit !== 1'b0 || bus.dirtyBit !== 1'b0) begin
          nFail++; $display("FAIL rst_mid_miss tag=%0d set=%0d got hit=%b dirty=%b exp 0/0", t, s, bus.hit, bus.dirtyBit);
        end
        commit();
      end
    // Fresh fills after reset must land in way order 0..3 and hit.
    apply(0, 0, 0, 1, A(3'b011, 1), 8'h00, 64'hCAFE_F00D_0000_0001); commit();
    apply(0, 1, 0, 0, A(3'b011, 1), 8'h00, '0);
    eval();
    nTests++;
    if (bus.hit !== 1'b1 || bus.dataOut !== 64'hCAFE_F00D_0000_0001) begin
      nFail++; $display("FAIL post_rst_fill got hit=%b data=%h exp 1/cafef00d00000001", bus.hit, bus.dataOut);
    end
    commit();
  endtask

  initial begin
    rst = 1'b1; bus.ren = 1'b0; bus.wen = 1'b0; bus.memWen = 1'b0;
    bus.blockAddr = '0; bus.bytesAccess = '0; bus.dataIn = '0;
    mReset();
    test_reset();
    test_directed();
    test_set_isolation();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
